// File: rtl/ir_line_packer.sv
// Packs a stream of 16-bit impulse-response samples into 1024-bit memory lines of 64 lanes.
// Optional build macro IR_LOAD_CHECKSUM_EN adds a running 32-bit sum of accepted samples.
module ir_line_packer #(
  parameter int IMPULSE_LENGTH = 48000
) (
  input  logic                audio_clk,
  input  logic                rst_in,
  input  logic                ir_start,
  input  logic [15:0]         ir_length,
  input  logic signed [15:0]  ir_sample_in,
  input  logic                ir_sample_valid,
  output logic                ir_sample_ready,
  output logic [15:0]         ir_write_addr,
  output logic [1023:0]       ir_write_data,
  output logic                ir_write_enable,
  output logic                impulse_in_memory_complete,
  output logic [31:0]         ir_checksum
);

  localparam int LANES = 64;
  localparam int MAX_LEN_CLAMPED = (IMPULSE_LENGTH > 65535) ? 65535 : IMPULSE_LENGTH;
  localparam logic [15:0] MAX_LEN = 16'(MAX_LEN_CLAMPED);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PACKING,
    ST_FLUSH,
    ST_DONE
  } state_t;

  state_t         state_reg;
  logic [1023:0]  line_buf_reg;
  logic [5:0]     lane_reg;
  logic [15:0]    line_idx_reg;
  logic [15:0]    count_reg;
  logic [15:0]    len_reg;
  logic           ready_reg;
  logic           wr_en_reg;
  logic [15:0]    wr_addr_reg;
  logic [1023:0]  wr_data_reg;
  logic           complete_reg;

  logic [15:0]    eff_len;
  logic [1023:0]  merged_line;
  logic           sample_accept;
  logic           last_sample;
  logic           start_ok;

  assign eff_len       = (ir_length > MAX_LEN) ? MAX_LEN : ir_length;
  assign sample_accept = ready_reg && ir_sample_valid;
  assign last_sample   = ((count_reg + 16'd1) == len_reg);
  assign start_ok      = ir_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));

  // Current line with the incoming sample dropped into its lane; lanes not yet
  // filled stay zero because the buffer is cleared after every write.
  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign merged_line[gi*16 +: 16] = (lane_reg == 6'(gi)) ? ir_sample_in
                                                             : line_buf_reg[gi*16 +: 16];
    end
  endgenerate

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      state_reg    <= ST_IDLE;
      line_buf_reg <= '0;
      lane_reg     <= '0;
      line_idx_reg <= '0;
      count_reg    <= '0;
      len_reg      <= '0;
      ready_reg    <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      complete_reg <= 1'b0;
    end else begin
      wr_en_reg <= 1'b0;
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (ir_start) begin
            len_reg      <= eff_len;
            count_reg    <= '0;
            lane_reg     <= '0;
            line_idx_reg <= '0;
            line_buf_reg <= '0;
            if (eff_len == 16'd0) begin
              state_reg    <= ST_DONE;
              ready_reg    <= 1'b0;
              complete_reg <= 1'b1;
            end else begin
              state_reg    <= ST_PACKING;
              ready_reg    <= 1'b1;
              complete_reg <= 1'b0;
            end
          end
        end
        ST_PACKING: begin
          if (sample_accept) begin
            count_reg <= count_reg + 16'd1;
            // A full line or the final (possibly partial) line goes out next cycle.
            if ((lane_reg == 6'd63) || last_sample) begin
              wr_en_reg    <= 1'b1;
              wr_addr_reg  <= line_idx_reg;
              wr_data_reg  <= merged_line;
              line_buf_reg <= '0;
              lane_reg     <= '0;
              line_idx_reg <= line_idx_reg + 16'd1;
            end else begin
              line_buf_reg <= merged_line;
              lane_reg     <= lane_reg + 6'd1;
            end
            if (last_sample) begin
              state_reg <= ST_FLUSH;
              ready_reg <= 1'b0;
            end
          end
        end
        ST_FLUSH: begin
          state_reg    <= ST_DONE;
          complete_reg <= 1'b1;
        end
        default: begin
          state_reg <= ST_IDLE;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign ir_sample_ready            = ready_reg;
  assign ir_write_enable            = wr_en_reg;
  assign ir_write_addr              = wr_addr_reg;
  assign ir_write_data              = wr_data_reg;
  assign impulse_in_memory_complete = complete_reg;

`ifdef IR_LOAD_CHECKSUM_EN
  logic [31:0] checksum_reg;

  always_ff @(posedge audio_clk or posedge rst_in) begin
    if (rst_in) begin
      checksum_reg <= '0;
    end else if (start_ok) begin
      checksum_reg <= '0;
    end else if (sample_accept) begin
      checksum_reg <= checksum_reg + {{16{ir_sample_in[15]}}, ir_sample_in};
    end
  end

  assign ir_checksum = checksum_reg;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
  assign ir_checksum     = '0;
`endif

endmodule

// File: tb/tb_ir_line_packer.sv
// Directed bench for ir_line_packer: default instance plus one built with IMPULSE_LENGTH=128.
module tb_ir_line_packer;

  logic               audio_clk = 1'b0;
  logic               rst_in;
  logic               ir_start;
  logic [15:0]        ir_length;
  logic signed [15:0] ir_sample_in;
  logic               ir_sample_valid;

  logic               ir_sample_ready, ir_sample_ready_s;
  logic [15:0]        ir_write_addr, ir_write_addr_s;
  logic [1023:0]      ir_write_data, ir_write_data_s;
  logic               ir_write_enable, ir_write_enable_s;
  logic               impulse_in_memory_complete, impulse_in_memory_complete_s;
  logic [31:0]        ir_checksum, ir_checksum_s;

  int checks = 0;
  int failures = 0;

`ifdef IR_LOAD_CHECKSUM_EN
  localparam bit CK_ON = 1'b1;
`else
  localparam bit CK_ON = 1'b0;
`endif

  always #5 audio_clk = ~audio_clk;

  ir_line_packer dut (
    .audio_clk                  (audio_clk),
    .rst_in                     (rst_in),
    .ir_start                   (ir_start),
    .ir_length                  (ir_length),
    .ir_sample_in               (ir_sample_in),
    .ir_sample_valid            (ir_sample_valid),
    .ir_sample_ready            (ir_sample_ready),
    .ir_write_addr              (ir_write_addr),
    .ir_write_data              (ir_write_data),
    .ir_write_enable            (ir_write_enable),
    .impulse_in_memory_complete (impulse_in_memory_complete),
    .ir_checksum                (ir_checksum)
  );

  ir_line_packer #(.IMPULSE_LENGTH(128)) dut_s (
    .audio_clk                  (audio_clk),
    .rst_in                     (rst_in),
    .ir_start                   (ir_start),
    .ir_length                  (ir_length),
    .ir_sample_in               (ir_sample_in),
    .ir_sample_valid            (ir_sample_valid),
    .ir_sample_ready            (ir_sample_ready_s),
    .ir_write_addr              (ir_write_addr_s),
    .ir_write_data              (ir_write_data_s),
    .ir_write_enable            (ir_write_enable_s),
    .impulse_in_memory_complete (impulse_in_memory_complete_s),
    .ir_checksum                (ir_checksum_s)
  );

  // Write / handshake log, sampled on the falling edge.
  logic [15:0]   wr_addr_log [0:63];
  logic [1023:0] wr_data_log [0:63];
  int            wr_count = 0;
  int            wr_count_s = 0;
  int            acc_s = 0;
  int            ready_cnt = 0;
  logic [15:0]   last_s_addr = '0;
  logic [1023:0] last_s_data = '0;

  always @(negedge audio_clk) begin
    if (ir_write_enable) begin
      if (wr_count < 64) begin
        wr_addr_log[wr_count] = ir_write_addr;
        wr_data_log[wr_count] = ir_write_data;
      end
      $display("write addr=%0d", ir_write_addr);
      wr_count = wr_count + 1;
    end
    if (ir_write_enable_s) begin
      last_s_addr = ir_write_addr_s;
      last_s_data = ir_write_data_s;
      wr_count_s  = wr_count_s + 1;
    end
    if (ir_sample_ready_s && ir_sample_valid) acc_s = acc_s + 1;
    if (ir_sample_ready) ready_cnt = ready_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start(input logic [15:0] len);
    ir_length = len;
    ir_start  = 1'b1;
    @(posedge audio_clk); #1;
    ir_start  = 1'b0;
  endtask

  task automatic idle(input int n);
    ir_sample_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge audio_clk); #1;
    end
  endtask

  // Holds valid until the default instance takes the sample.
  task automatic send(input logic [15:0] v);
    logic hit;
    int   n;
    ir_sample_valid = 1'b1;
    ir_sample_in    = v;
    n = 0;
    while (1) begin
      hit = ir_sample_ready;
      @(posedge audio_clk); #1;
      if (hit) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL send_timeout: got ready=0 for %0d cycles required ready=1", n);
        break;
      end
    end
    ir_sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; ir_start = 1'b0; ir_length = '0;
    ir_sample_in = '0; ir_sample_valid = 1'b0;
    #12;
    checks++; if (ir_sample_ready !== 1'b0) begin failures++; $display("FAIL rst_ready: got %b required 0", ir_sample_ready); end
    checks++; if (ir_write_enable !== 1'b0) begin failures++; $display("FAIL rst_wren: got %b required 0", ir_write_enable); end
    checks++; if (ir_write_addr !== 16'd0) begin failures++; $display("FAIL rst_addr: got %0h required 0", ir_write_addr); end
    checks++; if (ir_write_data !== '0) begin failures++; $display("FAIL rst_data: got %0h required 0", ir_write_data); end
    checks++; if (impulse_in_memory_complete !== 1'b0) begin failures++; $display("FAIL rst_complete: got %b required 0", impulse_in_memory_complete); end
    checks++; if (ir_checksum !== 32'd0) begin failures++; $display("FAIL rst_checksum: got %0h required 0", ir_checksum); end
    @(posedge audio_clk); #1;
    rst_in = 1'b0;
    idle(2);
    checks++; if (ir_sample_ready !== 1'b0) begin failures++; $display("FAIL idle_ready: got %b required 0", ir_sample_ready); end
    $display("test_reset done");
  endtask

  task automatic test_zero_length();
    int wbase, rbase;
    wbase = wr_count; rbase = ready_cnt;
    pulse_start(16'd0);
    checks++; if (impulse_in_memory_complete !== 1'b1) begin failures++; $display("FAIL zero_complete: got %b required 1", impulse_in_memory_complete); end
    idle(4);
    checks++; if (wr_count - wbase !== 0) begin failures++; $display("FAIL zero_writes: got %0d required 0", wr_count - wbase); end
    checks++; if (ready_cnt - rbase !== 0) begin failures++; $display("FAIL zero_ready: got %0d ready cycles required 0", ready_cnt - rbase); end
    checks++; if (impulse_in_memory_complete !== 1'b1) begin failures++; $display("FAIL zero_hold: got %b required 1", impulse_in_memory_complete); end
    $display("test_zero_length done");
  endtask

  task automatic test_single_line();
    logic [1023:0] exp;
    int wbase;
    wbase = wr_count;
    for (int i = 0; i < 64; i++) exp[i*16 +: 16] = 16'(i + 1);
    pulse_start(16'd64);
    for (int k = 0; k < 64; k++) send(16'(k + 1));
    checks++; if (ir_write_enable !== 1'b1) begin failures++; $display("FAIL single_wren: got %b required 1", ir_write_enable); end
    checks++; if (ir_write_addr !== 16'd0) begin failures++; $display("FAIL single_addr: got %0d required 0", ir_write_addr); end
    checks++; if (ir_write_data !== exp) begin failures++; $display("FAIL single_data: got %0h required %0h", ir_write_data, exp); end
    checks++; if (impulse_in_memory_complete !== 1'b0) begin failures++; $display("FAIL single_early_complete: got %b required 0", impulse_in_memory_complete); end
    @(posedge audio_clk); #1;
    checks++; if (impulse_in_memory_complete !== 1'b1) begin failures++; $display("FAIL single_complete: got %b required 1", impulse_in_memory_complete); end
    checks++; if (ir_write_enable !== 1'b0) begin failures++; $display("FAIL single_wren_off: got %b required 0", ir_write_enable); end
    checks++; if (ir_checksum !== (CK_ON ? 32'd2080 : 32'd0)) begin failures++; $display("FAIL single_checksum: got %0d required %0d", ir_checksum, CK_ON ? 2080 : 0); end
    idle(2);
    checks++; if (ir_write_data !== exp) begin failures++; $display("FAIL single_hold_data: got %0h required %0h", ir_write_data, exp); end
    checks++; if (wr_count - wbase !== 1) begin failures++; $display("FAIL single_count: got %0d required 1", wr_count - wbase); end
    $display("test_single_line done");
  endtask

  task automatic test_partial_flush();
    logic [1023:0] exp;
    int wbase, s;
    wbase = wr_count;
    pulse_start(16'd130);
    for (int k = 0; k < 130; k++) send(16'(k));
    idle(3);
    checks++; if (wr_count - wbase !== 3) begin failures++; $display("FAIL partial_count: got %0d required 3", wr_count - wbase); end
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < 64; i++) begin
        s = j * 64 + i;
        exp[i*16 +: 16] = (s < 130) ? 16'(s) : 16'd0;
      end
      checks++; if (wr_addr_log[wbase + j] !== 16'(j)) begin failures++; $display("FAIL partial_addr%0d: got %0d required %0d", j, wr_addr_log[wbase + j], j); end
      checks++; if (wr_data_log[wbase + j] !== exp) begin failures++; $display("FAIL partial_data%0d: got %0h required %0h", j, wr_data_log[wbase + j], exp); end
    end
    checks++; if (ir_checksum !== (CK_ON ? 32'd8385 : 32'd0)) begin failures++; $display("FAIL partial_checksum: got %0d required %0d", ir_checksum, CK_ON ? 8385 : 0); end
    $display("test_partial_flush done");
  endtask

  task automatic test_toggle_restart();
    logic [1023:0] exp;
    int wbase;
    wbase = wr_count;
    pulse_start(16'd100);
    for (int k = 0; k < 100; k++) begin
      if (k == 30) begin ir_start = 1'b1; ir_length = 16'd5; end
      send(16'(1000 + k));
      ir_start = 1'b0;
      idle(1);
    end
    idle(3);
    checks++; if (wr_count - wbase !== 2) begin failures++; $display("FAIL toggle_count: got %0d required 2", wr_count - wbase); end
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < 64; i++)
        exp[i*16 +: 16] = (j * 64 + i < 100) ? 16'(1000 + j * 64 + i) : 16'd0;
      checks++; if (wr_addr_log[wbase + j] !== 16'(j)) begin failures++; $display("FAIL toggle_addr%0d: got %0d required %0d", j, wr_addr_log[wbase + j], j); end
      checks++; if (wr_data_log[wbase + j] !== exp) begin failures++; $display("FAIL toggle_data%0d: got %0h required %0h", j, wr_data_log[wbase + j], exp); end
    end
    checks++; if (impulse_in_memory_complete !== 1'b1) begin failures++; $display("FAIL toggle_complete: got %b required 1", impulse_in_memory_complete); end
    checks++; if (ir_checksum !== (CK_ON ? 32'd104950 : 32'd0)) begin failures++; $display("FAIL toggle_checksum: got %0d required %0d", ir_checksum, CK_ON ? 104950 : 0); end
    $display("test_toggle_restart done");
  endtask

  task automatic test_reset_midload();
    logic [1023:0] exp;
    int wbase;
    pulse_start(16'd100);
    for (int k = 0; k < 40; k++) send(16'd7);
    wbase = wr_count;
    #2 rst_in = 1'b1;
    #1;
    checks++; if (ir_sample_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready: got %b required 0", ir_sample_ready); end
    checks++; if (ir_write_addr !== 16'd0) begin failures++; $display("FAIL mid_rst_addr: got %0d required 0", ir_write_addr); end
    checks++; if (ir_write_data !== '0) begin failures++; $display("FAIL mid_rst_data: got %0h required 0", ir_write_data); end
    checks++; if (impulse_in_memory_complete !== 1'b0) begin failures++; $display("FAIL mid_rst_complete: got %b required 0", impulse_in_memory_complete); end
    checks++; if (ir_checksum !== 32'd0) begin failures++; $display("FAIL mid_rst_checksum: got %0h required 0", ir_checksum); end
    @(posedge audio_clk); @(posedge audio_clk); #1;
    rst_in = 1'b0;
    idle(2);
    checks++; if (wr_count - wbase !== 0) begin failures++; $display("FAIL mid_abandon_writes: got %0d required 0", wr_count - wbase); end
    pulse_start(16'd64);
    for (int k = 0; k < 64; k++) send(16'hFFFF);
    idle(3);
    exp = '1;
    checks++; if (wr_count - wbase !== 1) begin failures++; $display("FAIL mid_count: got %0d required 1", wr_count - wbase); end
    checks++; if (wr_addr_log[wbase] !== 16'd0) begin failures++; $display("FAIL mid_addr: got %0d required 0", wr_addr_log[wbase]); end
    checks++; if (wr_data_log[wbase] !== exp) begin failures++; $display("FAIL mid_data: got %0h required %0h", wr_data_log[wbase], exp); end
    checks++; if (ir_checksum !== (CK_ON ? 32'hFFFFFFC0 : 32'd0)) begin failures++; $display("FAIL mid_checksum: got %0h required %0h", ir_checksum, CK_ON ? 32'hFFFFFFC0 : 32'd0); end
    $display("test_reset_midload done");
  endtask

  task automatic test_clamp();
    logic [1023:0] exp;
    int wbase, wbase_s, abase;
    wbase = wr_count; wbase_s = wr_count_s; abase = acc_s;
    pulse_start(16'd200);
    for (int k = 0; k < 210; k++) begin
      ir_sample_valid = 1'b1;
      ir_sample_in    = 16'(k);
      @(posedge audio_clk); #1;
    end
    idle(3);
    for (int i = 0; i < 64; i++) exp[i*16 +: 16] = 16'(64 + i);
    checks++; if (acc_s - abase !== 128) begin failures++; $display("FAIL clamp_accepted: got %0d required 128", acc_s - abase); end
    checks++; if (wr_count_s - wbase_s !== 2) begin failures++; $display("FAIL clamp_writes: got %0d required 2", wr_count_s - wbase_s); end
    checks++; if (last_s_addr !== 16'd1) begin failures++; $display("FAIL clamp_last_addr: got %0d required 1", last_s_addr); end
    checks++; if (last_s_data !== exp) begin failures++; $display("FAIL clamp_last_data: got %0h required %0h", last_s_data, exp); end
    checks++; if (ir_sample_ready_s !== 1'b0) begin failures++; $display("FAIL clamp_ready: got %b required 0", ir_sample_ready_s); end
    checks++; if (impulse_in_memory_complete_s !== 1'b1) begin failures++; $display("FAIL clamp_complete: got %b required 1", impulse_in_memory_complete_s); end
    checks++; if (wr_count - wbase !== 4) begin failures++; $display("FAIL unclamped_writes: got %0d required 4", wr_count - wbase); end
    $display("test_clamp done");
  endtask

  initial begin
    test_reset();
    test_zero_length();
    test_single_line();
    test_partial_flush();
    test_toggle_restart();
    test_reset_midload();
    test_clamp();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ir_line_packer.md
IR_LINE_PACKER -- requirements
Module: ir_line_packer

Interface
REQ-001 SHALL have parameter IMPULSE_LENGTH, default 48000, giving the maximum number of impulse-response samples accepted per load.
REQ-002 SHALL have port audio_clk, input, 1, the single clock; all logic is rising-edge.
REQ-003 SHALL have port rst_in, input, 1, reset; one clock; reset is asynchronous and active-high.
REQ-004 SHALL have port ir_start, input, 1, a one-cycle pulse that begins a load.
REQ-005 SHALL have port ir_length, input, 16, the sample count for the load, sampled on ir_start.
REQ-006 SHALL have port ir_sample_in, input, 16 signed, the IR sample.
REQ-007 SHALL have port ir_sample_valid, input, 1, meaning the sample is present.
REQ-008 SHALL have port ir_sample_ready, output, 1, meaning the block accepts a sample this cycle.
REQ-009 SHALL have port ir_write_addr, output, 16, the memory line address.
REQ-010 SHALL have port ir_write_data, output, 1024, the packed line of 64 samples.
REQ-011 SHALL have port ir_write_enable, output, 1, a one-cycle line write strobe.
REQ-012 SHALL have port impulse_in_memory_complete, output, 1, meaning the load is finished.
REQ-013 SHALL have port ir_checksum, output, 32, the sample sum (see Configuration).

Function
REQ-014 States SHALL be IDLE, PACKING, FLUSH and DONE.
REQ-015 IDLE->PACKING SHALL occur on ir_start when the effective length is nonzero; IDLE->DONE SHALL occur on ir_start when the effective length is 0, with no writes.
REQ-016 Effective length SHALL be min(ir_length, IMPULSE_LENGTH).
REQ-017 ir_sample_ready SHALL be 1 only in PACKING; a sample is accepted when valid and ready are both 1.
REQ-018 Accepted sample k (0-based) SHALL occupy bits [16*(k mod 64)+15 : 16*(k mod 64)] of line floor(k/64).
REQ-019 When sample k with k mod 64 = 63 is accepted in cycle N, ir_write_enable SHALL be 1 in cycle N+1 with ir_write_addr = floor(k/64) and the full line on ir_write_data.
REQ-020 When the final sample is accepted in cycle N, the block SHALL enter FLUSH. If the line is partial, the unused lanes SHALL be written as zero and the line written in cycle N+1. If the line is full, the normal write of REQ-019 applies.
REQ-021 FLUSH->DONE SHALL occur in the cycle after the final write; impulse_in_memory_complete SHALL be 1 in DONE.
REQ-022 impulse_in_memory_complete SHALL hold until the next ir_start. On that ir_start it SHALL clear, and the new load SHALL begin at line 0 with a zeroed line buffer.
REQ-023 ir_start in PACKING or FLUSH SHALL be ignored.
REQ-024 ir_sample_valid outside PACKING SHALL be ignored and SHALL NOT modify the buffer.
REQ-025 Each line SHALL be written exactly once; the number of writes SHALL be ceil(len/64).
REQ-026 ir_write_data and ir_write_addr SHALL hold their last values when ir_write_enable is 0.

Reset
REQ-027 Asserting rst_in SHALL immediately force state IDLE, ir_sample_ready=0, ir_write_enable=0, ir_write_addr=0, ir_write_data=0, impulse_in_memory_complete=0, ir_checksum=0, and sample count 0.
REQ-028 Reset mid-load SHALL abandon the load; no further writes SHALL occur and the first sample after the next ir_start SHALL be lane 0 of line 0.

Configuration
REQ-029 With macro IR_LOAD_CHECKSUM_EN defined, ir_checksum SHALL be cleared on an accepted ir_start, SHALL accumulate the sign-extended value of each accepted sample (mod 2^32), and SHALL be final when complete rises.
REQ-030 Without IR_LOAD_CHECKSUM_EN, ir_checksum SHALL be constant 0 and no accumulator logic SHALL be present.

Verification
REQ-031 Case: ir_length=64, samples 1..64 back-to-back. Required response: one write, addr 0, lane i = i+1, complete rises 1 cycle after the write, checksum = 2080 (macro on).
REQ-032 Case: ir_length=130, samples k = k. Required response: writes at addr 0, 1, 2; line 2 lanes 0-1 = 128, 129 and lanes 2-63 = 0; exactly 3 writes.
REQ-033 Case: ir_length=0. Required response: no writes, complete = 1 within 1 cycle of ir_start, ready never 1.
REQ-034 Case: ir_length=100, valid toggling 1/0 each cycle, with ir_start re-pulsed mid-load. Required response: the re-pulse is ignored; 100 samples produce 2 writes with correct lanes.
REQ-035 Case: rst_in asserted after 40 samples, then ir_length=64 with samples of -1. Required response: outputs zero during reset; exactly one write, addr 0, all lanes 0xFFFF; checksum = 0xFFFFFFC0.
REQ-036 Case: IMPULSE_LENGTH=128, ir_length=200. Required response: 128 samples accepted, 2 writes, then ready = 0 and complete = 1.
